// File: rtl/mem_mgr_wbuf_pkg.sv
// Shared types and helpers for the memory front-end and its write buffer.
package mem_mgr_wbuf_pkg;

  // Access size codes; the encoding is log2 of the byte count.
  typedef enum logic [2:0] {
    SzB = 3'd0,
    SzH = 3'd1,
    SzW = 3'd2,
    SzD = 3'd3,
    SzQ = 3'd4
  } size_e;

  // Widest supported word is 128 bits, so masks are built at 16 lanes and trimmed by the caller.
  localparam int unsigned MaxBytes = 16;

  // Byte-lane mask for an access of the given size starting at lane off.
  function automatic logic [MaxBytes-1:0] size_to_mask(input logic [2:0] size,
                                                       input logic [3:0] off);
    logic [MaxBytes-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      if (i < (32'd1 << size)) m[i] = 1'b1;
    end
    return m << off;
  endfunction

  // True when the address is not a multiple of the size, or the size exceeds the word.
  function automatic logic is_misaligned(input logic [3:0] addr_lo, input logic [2:0] size,
                                         input int unsigned log2_bytes);
    logic [3:0] lo_mask;
    if (32'(size) > log2_bytes) return 1'b1;
    lo_mask = 4'((32'd1 << size) - 32'd1);
    return (addr_lo & lo_mask) != 4'd0;
  endfunction

endpackage

// File: rtl/mem_mgr_wbuf_fifo.sv
// Circular write buffer with per-lane youngest-match forwarding for a query word address.
module mem_mgr_wbuf_fifo #(
  parameter int unsigned Bytes = 4,
  parameter int unsigned AddrW = 30,
  parameter int unsigned Depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq,
  input  logic [AddrW-1:0]   enq_addr,
  input  logic [Bytes-1:0]   enq_mask,
  input  logic [Bytes*8-1:0] enq_data,
  input  logic               deq,
  output logic [AddrW-1:0]   head_addr,
  output logic [Bytes-1:0]   head_mask,
  output logic [Bytes*8-1:0] head_data,
  output logic               full,
  output logic               empty,
  input  logic [AddrW-1:0]   query_addr,
  output logic [Bytes-1:0]   fwd_hit,
  output logic [Bytes*8-1:0] fwd_data
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  typedef struct packed {
    logic [AddrW-1:0]   addr;
    logic [Bytes-1:0]   mask;
    logic [Bytes*8-1:0] data;
  } wb_entry_t;

  wb_entry_t       entries_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] idx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + 1'b1;
  endfunction

  assign full      = (32'(count_q) == Depth);
  assign empty     = (count_q == '0);
  assign head_addr = entries_q[rd_ptr_q].addr;
  assign head_mask = entries_q[rd_ptr_q].mask;
  assign head_data = entries_q[rd_ptr_q].data;

  // Pointer and occupancy bookkeeping; enqueue and dequeue together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (enq && !deq) count_q <= count_q + 1'b1;
      else if (deq && !enq) count_q <= count_q - 1'b1;
    end
  end

  // Entry storage needs no reset; only slots inside the occupied window are ever read.
  always_ff @(posedge clk) begin
    if (enq) entries_q[wr_ptr_q] <= '{addr: enq_addr, mask: enq_mask, data: enq_data};
  end

  // Walk oldest to youngest so a later match overrides an earlier one lane by lane.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = PtrW'((32'(rd_ptr_q) + i) % Depth);
      if (i < 32'(count_q) && entries_q[idx].addr == query_addr) begin
        for (int unsigned b = 0; b < Bytes; b++) begin
          if (entries_q[idx].mask[b]) begin
            fwd_hit[b]          = 1'b1;
            fwd_data[b*8 +: 8]  = entries_q[idx].data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Occupancy sanity: never overfill, never pop an empty buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enq && full && !deq));
      assert (!(deq && empty));
      assert (32'(count_q) <= Depth);
    end
  end

endmodule

// File: rtl/mem_mgr_wbuf.sv
// Data/instruction memory front-end: loads own RAM port A, stores queue and drain when idle.
module mem_mgr_wbuf
  import mem_mgr_wbuf_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BYTES     = WIDTH / 8,
  parameter int unsigned MEM_WORDS = 'h1000,
  parameter int unsigned WB_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic             we,
  input  logic [2:0]       wr_bytes,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_stall,
  output logic             wr_misaligned,
  input  logic [WIDTH-1:0] rd_addr,
  input  logic             re,
  input  logic [2:0]       rd_bytes,
  input  logic             rd_unsigned,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_misaligned,
  input  logic             flush,
  output logic             wb_empty,
  input  logic [WIDTH-1:0] inst_addr,
  output logic [WIDTH-1:0] inst_data
);

  localparam int unsigned OffW  = $clog2(BYTES);
  localparam int unsigned AddrW = WIDTH - OffW;
  localparam int unsigned MemAw = $clog2(MEM_WORDS);

  logic [AddrW-1:0] wr_waddr, rd_waddr, head_addr;
  logic [BYTES-1:0] wr_mask, head_mask, fifo_hit, fwd_mask_d, fwd_mask_q, wa_mask;
  logic [WIDTH-1:0] wr_sdata, head_data, fifo_fwd, fwd_data_d, fwd_data_q, wa_data;
  logic [WIDTH-1:0] ram_rd_q, inst_q, merged, shifted;
  logic [MemAw-1:0] wa_idx, rd_idx, inst_idx;
  logic             full, empty, load_ok, st_ok, enq, deq, direct, wa_en;
  logic [OffW-1:0]  shift_q;
  size_e            size_q;
  logic             uns_q;
  int unsigned      nbits;
  logic             sign;
  logic             unused_addr;

  logic [WIDTH-1:0] mem_q [MEM_WORDS];

  assign wr_waddr = wr_addr[WIDTH-1:OffW];
  assign rd_waddr = rd_addr[WIDTH-1:OffW];
  assign rd_idx   = rd_waddr[MemAw-1:0];
  assign inst_idx = inst_addr[OffW +: MemAw];
  assign wr_mask  = BYTES'(size_to_mask(wr_bytes, 4'(wr_addr[OffW-1:0])));
  assign wr_sdata = wr_data << {wr_addr[OffW-1:0], 3'b000};

  assign wr_misaligned = we & is_misaligned(4'(wr_addr[OffW-1:0]), wr_bytes, OffW);
  assign rd_misaligned = re & is_misaligned(4'(rd_addr[OffW-1:0]), rd_bytes, OffW);

  // Port A arbitration: load first, then drain the head, then a direct store into an empty buffer.
  assign load_ok  = re & ~rd_misaligned;
  assign wr_stall = we & ((full & re) | (flush & ~empty));
  assign st_ok    = ~rst & we & ~wr_misaligned & ~wr_stall;
  assign enq      = st_ok & (load_ok | ~empty);
  assign direct   = st_ok & ~load_ok & empty;
  assign deq      = ~rst & ~load_ok & ~empty;
  assign wb_empty = empty;

  assign wa_en   = deq | direct;
  assign wa_idx  = deq ? head_addr[MemAw-1:0] : wr_waddr[MemAw-1:0];
  assign wa_mask = deq ? head_mask : wr_mask;
  assign wa_data = deq ? head_data : wr_sdata;

  assign unused_addr = ^{inst_addr[WIDTH-1:OffW+MemAw], inst_addr[OffW-1:0],
                         head_addr[AddrW-1:MemAw]};

  mem_mgr_wbuf_fifo #(
    .Bytes(BYTES),
    .AddrW(AddrW),
    .Depth(WB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .enq       (enq),
    .enq_addr  (wr_waddr),
    .enq_mask  (wr_mask),
    .enq_data  (wr_sdata),
    .deq       (deq),
    .head_addr (head_addr),
    .head_mask (head_mask),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .query_addr(rd_waddr),
    .fwd_hit   (fifo_hit),
    .fwd_data  (fifo_fwd)
  );

  // A store accepted alongside the load is younger than anything buffered (write-first).
  always_comb begin
    fwd_mask_d = fifo_hit;
    fwd_data_d = fifo_fwd;
    if (enq && wr_waddr == rd_waddr) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_mask[b]) begin
          fwd_mask_d[b]         = 1'b1;
          fwd_data_d[b*8 +: 8]  = wr_sdata[b*8 +: 8];
        end
      end
    end
  end

  // Read-out pipeline: capture forward lanes and shaping controls with the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q     <= SzW;
      uns_q      <= 1'b0;
      shift_q    <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else if (load_ok) begin
      size_q     <= size_e'(rd_bytes);
      uns_q      <= rd_unsigned;
      shift_q    <= rd_addr[OffW-1:0];
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Byte-enabled dual-port RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (wa_en) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wa_mask[b]) mem_q[wa_idx][b*8 +: 8] <= wa_data[b*8 +: 8];
      end
    end
    if (load_ok) ram_rd_q <= mem_q[rd_idx];
    inst_q <= mem_q[inst_idx];
  end

  assign inst_data = inst_q;

  // Merge forwarded lanes over RAM, align to lane 0, then zero/sign-extend.
  always_comb begin
    merged = ram_rd_q;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (fwd_mask_q[b]) merged[b*8 +: 8] = fwd_data_q[b*8 +: 8];
    end
    shifted = merged >> {shift_q, 3'b000};
    nbits   = 32'd8 << size_q;
    sign    = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i + 1 == nbits) sign = ~uns_q & shifted[i];
    end
    rd_data = shifted;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i >= nbits) rd_data[i] = sign;
    end
  end

endmodule

// File: tb/tb_mem_mgr_wbuf.sv
// Randomised and directed bench for mem_mgr_wbuf against a byte-level memory/queue model.
module tb_mem_mgr_wbuf;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0, inst_addr = '0;
  logic        we = 1'b0, re = 1'b0, rd_unsigned = 1'b0, flush = 1'b0;
  logic [2:0]  wr_bytes = '0, rd_bytes = '0;
  logic        wr_stall, wr_misaligned, rd_misaligned, wb_empty;
  logic [31:0] rd_data, inst_data;

  always #5 clk = ~clk;

  mem_mgr_wbuf #(.WIDTH(32), .MEM_WORDS('h1000), .WB_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_addr      (wr_addr),
    .we           (we),
    .wr_bytes     (wr_bytes),
    .wr_data      (wr_data),
    .wr_stall     (wr_stall),
    .wr_misaligned(wr_misaligned),
    .rd_addr      (rd_addr),
    .re           (re),
    .rd_bytes     (rd_bytes),
    .rd_unsigned  (rd_unsigned),
    .rd_data      (rd_data),
    .rd_misaligned(rd_misaligned),
    .flush        (flush),
    .wb_empty     (wb_empty),
    .inst_addr    (inst_addr),
    .inst_data    (inst_data)
  );

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Model: architectural bytes already in RAM plus an ordered list of pending stores.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } st_t;

  logic [7:0] ram_m [int];
  st_t        q [$];

  logic [31:0] last_rd;
  logic        last_stall, last_rdmis, last_wrmis;

  function automatic logic mis(input logic [31:0] a, input logic [2:0] sz);
    return sz > 3'd2 || (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic covers(input st_t s, input logic [31:0] a);
    return a >= s.addr && a < s.addr + (32'd1 << s.size);
  endfunction

  function automatic int get_byte(input logic [31:0] a, input st_t inc, input logic inc_v);
    if (inc_v && covers(inc, a)) return int'(inc.data[8*(a-inc.addr) +: 8]);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (covers(q[i], a)) return int'(q[i].data[8*(a-q[i].addr) +: 8]);
    end
    if (ram_m.exists(int'(a))) return int'(ram_m[int'(a)]);
    return -1;
  endfunction

  function automatic logic load_model(input logic [31:0] a, input logic [2:0] sz, input logic u,
                                      input st_t inc, input logic inc_v, output logic [31:0] val);
    int n;
    int b;
    n   = 1 << sz;
    val = '0;
    for (int k = 0; k < n; k++) begin
      b = get_byte(a + 32'(k), inc, inc_v);
      if (b < 0) return 1'b0;
      val[8*k +: 8] = 8'(b);
    end
    if (!u && n < 4 && val[8*n-1]) begin
      for (int k = 8 * n; k < 32; k++) val[k] = 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic void apply(input st_t s);
    for (int k = 0; k < (1 << s.size); k++) ram_m[int'(s.addr) + k] = s.data[8*k +: 8];
  endfunction

  // One clock: drive at the falling edge, check comb outputs, step the model, check registered ones.
  task automatic cycle(input logic w, input logic [31:0] wa, input logic [2:0] ws,
                       input logic [31:0] wdat, input logic r, input logic [31:0] ra,
                       input logic [2:0] rs, input logic ru, input logic fl);
    st_t         inc;
    int          cnt;
    int          b;
    logic        rmis, wmis, stall, load_ok, st_ok, ld_known, ia_known;
    logic [31:0] ld_exp, ia, ia_exp;
    we = w; wr_addr = wa; wr_bytes = ws; wr_data = wdat;
    re = r; rd_addr = ra; rd_bytes = rs; rd_unsigned = ru; flush = fl;
    ia = 32'($urandom_range(0, 32'h1ff)) << 2;
    inst_addr = ia;
    #1;
    cnt   = q.size();
    rmis  = r && mis(ra, rs);
    wmis  = w && mis(wa, ws);
    stall = w && ((cnt == D && r) || (fl && cnt != 0));
    check_eq("wr_stall", 32'(wr_stall), 32'(stall));
    check_eq("rd_misaligned", 32'(rd_misaligned), 32'(rmis));
    check_eq("wr_misaligned", 32'(wr_misaligned), 32'(wmis));
    check_eq("wb_empty", 32'(wb_empty), 32'(cnt == 0));
    last_stall = wr_stall; last_rdmis = rd_misaligned; last_wrmis = wr_misaligned;
    ia_known = 1'b1;
    ia_exp   = '0;
    for (int k = 0; k < 4; k++) begin
      if (ram_m.exists(int'(ia) + k)) ia_exp[8*k +: 8] = ram_m[int'(ia) + k];
      else ia_known = 1'b0;
    end
    load_ok  = r && !rmis;
    st_ok    = w && !wmis && !stall;
    inc      = '{addr: wa, size: ws, data: wdat};
    ld_known = 1'b0;
    ld_exp   = '0;
    if (load_ok) ld_known = load_model(ra, rs, ru, inc, st_ok, ld_exp);
    if (!load_ok && cnt > 0) apply(q.pop_front());
    if (st_ok) begin
      if (load_ok || cnt > 0) q.push_back(inc);
      else apply(inc);
    end
    b = 0;
    @(posedge clk);
    #1;
    last_rd = rd_data;
    if (load_ok && ld_known) check_eq("rd_data", rd_data, ld_exp);
    if (ia_known) check_eq("inst_data", inst_data, ia_exp);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 3'd0, '0, 1'b0, '0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] sz, input logic u);
    cycle(1'b0, '0, 3'd0, '0, 1'b1, a, sz, u, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * D && q.size() > 0; i++) idle();
    check_eq("drained", 32'(wb_empty), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr(input logic [2:0] sz);
    logic [31:0] a;
    a = 32'h500 + 32'($urandom_range(0, 63));
    if ($urandom_range(0, 9) < 7 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
    return a;
  endfunction

  initial begin
    int nst;
    logic [2:0] ws, rs;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_empty", 32'(wb_empty), 32'd1);
    check_eq("reset_stall", 32'(wr_stall), 32'd0);

    // Direct store into an empty buffer, then read it back.
    cycle(1'b1, 32'h100, 3'd2, 32'hDEADBEEF, 1'b0, '0, 3'd0, 1'b0, 1'b0);
    check_eq("t1_empty", 32'(wb_empty), 32'd1);
    load(32'h100, 3'd2, 1'b0);
    check_eq("t1_lw", last_rd, 32'hDEADBEEF);

    // Store held off by a load, drained on the next idle cycle.
    cycle(1'b1, 32'h104, 3'd0, 32'h7F, 1'b1, 32'h200, 3'd2, 1'b0, 1'b0);
    check_eq("t2_queued", 32'(wb_empty), 32'd0);
    idle();
    check_eq("t2_drained", 32'(wb_empty), 32'd1);
    load(32'h104, 3'd0, 1'b1);
    check_eq("t2_lbu", last_rd, 32'h7F);

    // Fill the buffer under loads; fifth store stalls, then goes in on an idle cycle.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h600 + 32'(4 * i), 3'd2, $urandom, 1'b1, 32'h100, 3'd2, 1'b0, 1'b0);
    cycle(1'b1, 32'h610, 3'd2, 32'h55AA55AA, 1'b1, 32'h100, 3'd2, 1'b0, 1'b0);
    check_eq("t3_full_stall", 32'(last_stall), 32'd1);
    cycle(1'b1, 32'h610, 3'd2, 32'h55AA55AA, 1'b0, '0, 3'd0, 1'b0, 1'b0);
    check_eq("t3_accept", 32'(last_stall), 32'd0);
    drain();

    // Youngest store wins per byte lane.
    cycle(1'b1, 32'h300, 3'd2, 32'h11223344, 1'b1, 32'h200, 3'd2, 1'b0, 1'b0);
    cycle(1'b1, 32'h301, 3'd0, 32'hAA, 1'b1, 32'h300, 3'd2, 1'b0, 1'b0);
    check_eq("t4_same_cycle", last_rd, 32'h1122AA44);
    load(32'h300, 3'd2, 1'b0);
    check_eq("t4_youngest", last_rd, 32'h1122AA44);

    // Write-first halfword with sign and zero extension.
    cycle(1'b1, 32'h402, 3'd1, 32'h8001, 1'b1, 32'h402, 3'd1, 1'b0, 1'b0);
    check_eq("t5_lh", last_rd, 32'hFFFF8001);
    load(32'h402, 3'd1, 1'b1);
    check_eq("t5_lhu", last_rd, 32'h00008001);
    drain();

    // Misalignment and flush.
    load(32'h3, 3'd2, 1'b0);
    check_eq("t6_lw_mis", 32'(last_rdmis), 32'd1);
    cycle(1'b1, 32'h3, 3'd0, 32'h5A, 1'b0, '0, 3'd0, 1'b0, 1'b0);
    check_eq("t6_sb_ok", 32'(last_wrmis), 32'd0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h700 + 32'(4 * i), 3'd2, $urandom, 1'b1, 32'h100, 3'd2, 1'b0, 1'b0);
    nst = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h710, 3'd2, 32'hCAFEF00D, 1'b0, '0, 3'd0, 1'b0, 1'b1);
      if (!last_stall) break;
      nst++;
    end
    check_eq("t6_flush_stalls", 32'(nst), 32'd3);
    load(32'h710, 3'd2, 1'b0);
    check_eq("t6_flush_store", last_rd, 32'hCAFEF00D);

    // Randomised traffic in a small window to provoke overlap, forwarding and stalls.
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 32'h500 + 32'(4 * i), 3'd2, $urandom, 1'b0, '0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      ws = 3'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 1)), rand_addr(ws), ws, $urandom, 1'($urandom_range(0, 1)),
            rand_addr(rs), rs, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
    drain();
    for (int i = 0; i < 16; i++) load(32'h500 + 32'(4 * i), 3'd2, 1'b0);

    // Reset with queued stores discards them; RAM keeps its old contents.
    cycle(1'b1, 32'h500, 3'd2, 32'h01020304, 1'b1, 32'h504, 3'd2, 1'b0, 1'b0);
    cycle(1'b1, 32'h504, 3'd2, 32'h05060708, 1'b1, 32'h508, 3'd2, 1'b0, 1'b0);
    rst = 1'b1;
    we = 1'b0; re = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    check_eq("rst_discard_empty", 32'(wb_empty), 32'd1);
    @(negedge clk);
    load(32'h500, 3'd2, 1'b0);
    load(32'h504, 3'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
